// File: rtl/wb_stage.sv
// Writeback stage: merges ALU (FIFO-buffered) and LSU (one-entry hold) results into one
// registered regfile write per cycle, with a combinational bypass of the in-flight write.
module wb_stage #(
    parameter int XLEN         = 32,
    parameter int AW           = 5,
    parameter int ALU_DEPTH    = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            rf_wen,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    input  logic [AW-1:0]   q_addr,
    output logic            q_hit,
    output logic [XLEN-1:0] q_data,
    output logic [31:0]     commit_cnt
);

    localparam int PW = $clog2(ALU_DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // ready depends only on registered state, never on the same-cycle valid.

    logic [AW-1:0]   fifo_rd_mem   [ALU_DEPTH];
    logic [XLEN-1:0] fifo_data_mem [ALU_DEPTH];
    logic [PW:0]     wr_ptr_q, wr_ptr_d;
    logic [PW:0]     rd_ptr_q, rd_ptr_d;

    logic            hold_valid_q, hold_valid_d;
    logic [AW-1:0]   hold_rd_q,    hold_rd_d;
    logic [XLEN-1:0] hold_data_q,  hold_data_d;

    logic [SW-1:0]   starve_q, starve_d;

    logic            rf_wen_q,   rf_wen_d;
    logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic [31:0]     commit_cnt_q, commit_cnt_d;

    logic            fifo_empty, fifo_full;
    logic            alu_pend, lsu_pend;
    logic            alu_win, lsu_win;
    logic            push, pop;
    logic [AW-1:0]   head_rd;
    logic [XLEN-1:0] head_data;
    logic            c_valid;
    logic [AW-1:0]   c_rd;
    logic [XLEN-1:0] c_data;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign alu_ready  = !fifo_full;
    assign lsu_ready  = !hold_valid_q;

    assign head_rd    = fifo_rd_mem[rd_ptr_q[PW-1:0]];
    assign head_data  = fifo_data_mem[rd_ptr_q[PW-1:0]];

    always_comb begin
        alu_pend = !fifo_empty;
        lsu_pend = hold_valid_q;
        alu_win  = alu_pend && (!lsu_pend || (starve_q == STARVE_MAX));
        lsu_win  = lsu_pend && !alu_win;
        push     = alu_valid && alu_ready && !flush;
        pop      = alu_win;
    end

    // A flush snaps the read pointer onto the write pointer; the dropped push keeps wr fixed.
    always_comb begin
        wr_ptr_d = wr_ptr_q + (PW+1)'(push);
        rd_ptr_d = flush ? wr_ptr_q : rd_ptr_q + (PW+1)'(pop);
    end

    always_comb begin
        starve_d = starve_q;
        if (flush || !alu_pend || alu_win) begin
            starve_d = '0;
        end else if (lsu_win && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_rd_d    = hold_rd_q;
        hold_data_d  = hold_data_q;
        if (lsu_win) begin
            hold_valid_d = 1'b0;
        end else if (lsu_valid && lsu_ready) begin
            hold_valid_d = 1'b1;
            hold_rd_d    = lsu_rd;
            hold_data_d  = lsu_data;
        end
    end

    // A flushed ALU head still consumes the arbitration slot but writes nothing.
    always_comb begin
        c_valid      = lsu_win || (alu_win && !flush);
        c_rd         = lsu_win ? hold_rd_q   : head_rd;
        c_data       = lsu_win ? hold_data_q : head_data;
        rf_wen_d     = c_valid && (c_rd != '0);
        rf_waddr_d   = rf_wen_d ? c_rd   : rf_waddr_q;
        rf_wdata_d   = rf_wen_d ? c_data : rf_wdata_q;
        commit_cnt_d = commit_cnt_q + 32'(rf_wen_d);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_mem[wr_ptr_q[PW-1:0]]   <= alu_rd;
            fifo_data_mem[wr_ptr_q[PW-1:0]] <= alu_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            hold_valid_q <= 1'b0;
            hold_rd_q    <= '0;
            hold_data_q  <= '0;
            starve_q     <= '0;
            rf_wen_q     <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            commit_cnt_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            hold_valid_q <= hold_valid_d;
            hold_rd_q    <= hold_rd_d;
            hold_data_q  <= hold_data_d;
            starve_q     <= starve_d;
            rf_wen_q     <= rf_wen_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            commit_cnt_q <= commit_cnt_d;
        end
    end

    assign rf_wen     = rf_wen_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign commit_cnt = commit_cnt_q;

    assign q_hit  = rf_wen_q && (rf_waddr_q == q_addr) && (q_addr != '0);
    assign q_data = q_hit ? rf_wdata_q : '0;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: hand-traced commit sequences for arbitration, x0, flush,
// async reset and commit counter wrap.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  q_addr;
    logic        q_hit;
    logic [31:0] q_data;
    logic [31:0] commit_cnt;

    int n_cmp = 0;
    int n_err = 0;

    wb_stage dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_rd     (lsu_rd),
        .lsu_data   (lsu_data),
        .rf_wen     (rf_wen),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .q_addr     (q_addr),
        .q_hit      (q_hit),
        .q_data     (q_data),
        .commit_cnt (commit_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_rf(input string tag, input logic wen, input logic [4:0] addr,
                          input logic [31:0] data);
        chk({tag, ".wen"},   32'(rf_wen),   32'(wen));
        chk({tag, ".waddr"}, 32'(rf_waddr), 32'(addr));
        chk({tag, ".wdata"}, rf_wdata,      data);
    endtask

    task automatic drive_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        alu_valid = v;
        alu_rd    = rd;
        alu_data  = d;
    endtask

    task automatic drive_lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        lsu_valid = v;
        lsu_rd    = rd;
        lsu_data  = d;
    endtask

    // Arbitration trace: ALU a_i = {rd i+1, A000_000i}, LSU l_i = {rd 16+i, B000_000i}
    logic        t2_wen   [12] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    logic [4:0]  t2_addr  [12] = '{5, 16, 1, 17, 2, 18, 3, 19, 4, 5, 6, 6};
    logic [31:0] t2_data  [12] = '{32'hDEADBEEF, 32'hB0000000, 32'hA0000000, 32'hB0000001,
                                   32'hA0000001, 32'hB0000002, 32'hA0000002, 32'hB0000003,
                                   32'hA0000003, 32'hA0000004, 32'hA0000005, 32'hA0000005};
    logic        t2_aready[12] = '{1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1};
    logic        t2_lready[12] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 1, 1, 1};
    int          t2_lidx  [7]  = '{0, 1, 1, 2, 2, 3, 3};

    // Flush trace: b_i = {rd 20+i, D000_000i}; LSU m0 {8,C0000000}, m1 {9,C0000001}, m2 {7,0x77}
    logic        t4_wen   [8] = '{0, 1, 1, 1, 1, 1, 0, 0};
    logic [4:0]  t4_addr  [8] = '{6, 8, 20, 9, 21, 7, 7, 7};
    logic [31:0] t4_data  [8] = '{32'hA0000005, 32'hC0000000, 32'hD0000000, 32'hC0000001,
                                  32'hD0000001, 32'h00000077, 32'h00000077, 32'h00000077};

    initial begin
        rst   = 1'b0;
        flush = 1'b0;
        drive_alu(1'b0, 5'd0, 32'h0);
        drive_lsu(1'b0, 5'd0, 32'h0);
        q_addr = 5'd0;

        #3;
        chk_rf("reset", 1'b0, 5'd0, 32'h0);
        chk("reset.alu_ready",  32'(alu_ready),  32'd1);
        chk("reset.lsu_ready",  32'(lsu_ready),  32'd1);
        chk("reset.commit_cnt", commit_cnt,      32'd0);
        chk("reset.q_hit",      32'(q_hit),      32'd0);
        #9;
        rst = 1'b1;
        step();

        // Single ALU write and bypass
        drive_alu(1'b1, 5'd5, 32'hDEADBEEF);
        step();
        drive_alu(1'b0, 5'd0, 32'h0);
        step();
        chk_rf("t1.commit", 1'b1, 5'd5, 32'hDEADBEEF);
        chk("t1.commit_cnt", commit_cnt, 32'd1);
        q_addr = 5'd5;
        #1;
        chk("t1.q_hit",  32'(q_hit), 32'd1);
        chk("t1.q_data", q_data,     32'hDEADBEEF);
        q_addr = 5'd4;
        #1;
        chk("t1.q_miss_hit",  32'(q_hit), 32'd0);
        chk("t1.q_miss_data", q_data,     32'h0);
        step();
        chk_rf("t1.idle", 1'b0, 5'd5, 32'hDEADBEEF);

        // ALU stream against an LSU hold refilled whenever it empties
        for (int c = 0; c < 12; c++) begin
            if (c <= 6) drive_alu(1'b1, 5'(c + 1), 32'hA0000000 + 32'(c));
            else        drive_alu(1'b0, 5'd0, 32'h0);
            if (c <= 6) drive_lsu(1'b1, 5'(16 + t2_lidx[c]), 32'hB0000000 + 32'(t2_lidx[c]));
            else        drive_lsu(1'b0, 5'd0, 32'h0);
            chk($sformatf("t2.c%0d.alu_ready", c), 32'(alu_ready), 32'(t2_aready[c]));
            chk($sformatf("t2.c%0d.lsu_ready", c), 32'(lsu_ready), 32'(t2_lready[c]));
            step();
            chk_rf($sformatf("t2.c%0d", c), t2_wen[c], t2_addr[c], t2_data[c]);
        end
        chk("t2.commit_cnt", commit_cnt, 32'd11);

        // x0 destination consumes a slot without writing
        drive_alu(1'b1, 5'd0, 32'h00001234);
        step();
        drive_alu(1'b0, 5'd0, 32'h0);
        step();
        chk_rf("t3.x0", 1'b0, 5'd6, 32'hA0000005);
        chk("t3.commit_cnt", commit_cnt, 32'd11);
        chk("t3.alu_ready",  32'(alu_ready), 32'd1);
        q_addr = 5'd0;
        #1;
        chk("t3.q0_hit",  32'(q_hit), 32'd0);
        chk("t3.q0_data", q_data,     32'h0);
        q_addr = 5'd6;
        #1;
        chk("t3.q6_hit", 32'(q_hit), 32'd0);

        // Flush with three FIFO entries and LSU rd=7 pending
        for (int c = 0; c < 8; c++) begin
            flush = (c == 5);
            if (c <= 4)      drive_alu(1'b1, 5'(20 + c), 32'hD0000000 + 32'(c));
            else if (c == 5) drive_alu(1'b1, 5'd25, 32'hD0000005);
            else             drive_alu(1'b0, 5'd0, 32'h0);
            case (c)
                0:       drive_lsu(1'b1, 5'd8, 32'hC0000000);
                2:       drive_lsu(1'b1, 5'd9, 32'hC0000001);
                4:       drive_lsu(1'b1, 5'd7, 32'h00000077);
                default: drive_lsu(1'b0, 5'd0, 32'h0);
            endcase
            step();
            chk_rf($sformatf("t4.c%0d", c), t4_wen[c], t4_addr[c], t4_data[c]);
            if (c == 5) begin
                flush = 1'b0;
                chk("t4.alu_ready_after_flush", 32'(alu_ready), 32'd1);
                q_addr = 5'd7;
                #1;
                chk("t4.q7_hit",  32'(q_hit), 32'd1);
                chk("t4.q7_data", q_data,     32'h00000077);
            end
        end
        chk("t4.commit_cnt", commit_cnt, 32'd16);

        // Flush while the ALU head would win alone
        drive_alu(1'b1, 5'd3, 32'hE0000000);
        step();
        drive_alu(1'b0, 5'd0, 32'h0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk_rf("t4b.flushed", 1'b0, 5'd7, 32'h00000077);
        step();
        chk_rf("t4b.after", 1'b0, 5'd7, 32'h00000077);
        chk("t4b.commit_cnt", commit_cnt, 32'd16);

        // Asynchronous reset mid-stream
        drive_alu(1'b1, 5'd10, 32'hF0000000);
        drive_lsu(1'b1, 5'd11, 32'hF1000000);
        step();
        drive_alu(1'b1, 5'd12, 32'hF0000001);
        drive_lsu(1'b0, 5'd0, 32'h0);
        step();
        chk_rf("t5.pre", 1'b1, 5'd11, 32'hF1000000);
        drive_alu(1'b1, 5'd13, 32'hF0000002);
        drive_lsu(1'b1, 5'd14, 32'hF1000001);
        #2;
        rst = 1'b0;
        #1;
        chk_rf("t5.async", 1'b0, 5'd0, 32'h0);
        chk("t5.commit_cnt", commit_cnt,      32'd0);
        chk("t5.alu_ready",  32'(alu_ready),  32'd1);
        chk("t5.lsu_ready",  32'(lsu_ready),  32'd1);
        drive_alu(1'b0, 5'd0, 32'h0);
        drive_lsu(1'b0, 5'd0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk_rf($sformatf("t5.post%0d", c), 1'b0, 5'd0, 32'h0);
        end
        chk("t5.post_cnt", commit_cnt, 32'd0);

        // Commit counter wrap
        force dut.commit_cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.commit_cnt_q;
        drive_alu(1'b1, 5'd2, 32'h00000055);
        step();
        drive_alu(1'b0, 5'd0, 32'h0);
        step();
        chk_rf("t6.commit", 1'b1, 5'd2, 32'h00000055);
        chk("t6.commit_cnt_wrap", commit_cnt, 32'd0);
        step();
        chk("t6.commit_cnt_hold", commit_cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
